// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared state type and default sizing for the packet arbiter
package axis_arb_pkg;
  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} arb_state_e;
  localparam int DEF_N_SRC  = 4;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_CFG_W  = 2;
  localparam int BEAT_CNT_W = 16;
endpackage

// File: rtl/axis_pkt_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search starting at ptr_i, wrapping at N-1
module rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);
  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   sum;
  // rotate so bit 0 is the source at ptr_i; lowest set bit is the winner offset
  assign rot = N'({req_i, req_i} >> ptr_i);
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = W'(i);
  end
  assign sum   = {1'b0, ptr_i} + {1'b0, off};
  assign idx_o = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
  assign any_o = |req_i;
  assign gnt_o = any_o ? (N'(1) << idx_o) : '0;
endmodule

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-locked round-robin merge of N AXI-Stream sources
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int N_SRC  = DEF_N_SRC,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CFG_W  = DEF_CFG_W
) (
  input  logic                       clk_p,
  input  logic                       rst_p,
  input  logic [N_SRC*DATA_W-1:0]    src_tdata,
  input  logic [N_SRC-1:0]           src_tvalid,
  input  logic [N_SRC-1:0]           src_tlast,
  output logic [N_SRC-1:0]           src_tready,
  input  logic [N_SRC*CFG_W-1:0]     src_cfg,
  input  logic [N_SRC-1:0]           src_en,
  output logic [DATA_W-1:0]          m_axis_data,
  output logic                       m_axis_valid,
  output logic                       m_axis_last,
  input  logic                       m_axis_ready,
  output logic [CFG_W-1:0]           cfg,
  output logic [$clog2(N_SRC)-1:0]   grant_id,
  output logic                       busy,
  output logic                       pkt_done,
  output logic [BEAT_CNT_W-1:0]      beat_cnt
);
  localparam int IDX_W = $clog2(N_SRC);
  arb_state_e state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, win_idx;
  logic [N_SRC-1:0] win_gnt;
  logic [CFG_W-1:0] cfg_q, cfg_d, win_cfg;
  logic [BEAT_CNT_W-1:0] beat_q, beat_d;
  logic pkt_done_q, pkt_done_d, any_req, xfer, hs;
  logic [DATA_W-1:0] tdata_a [N_SRC];
  for (genvar s = 0; s < N_SRC; s++) begin : g_unpack
    assign tdata_a[s] = src_tdata[s*DATA_W +: DATA_W];
  end
  rr_picker #(.N(N_SRC), .W(IDX_W)) u_pick (
    .req_i(src_tvalid & src_en),
    .ptr_i(rr_ptr_q),
    .gnt_o(win_gnt),
    .idx_o(win_idx),
    .any_o(any_req)
  );
  always_comb begin
    win_cfg = '0;
    for (int i = 0; i < N_SRC; i++) win_cfg |= win_gnt[i] ? src_cfg[i*CFG_W +: CFG_W] : '0;
  end
  assign xfer         = (state_q == XFER);
  assign m_axis_data  = tdata_a[grant_q];
  assign m_axis_valid = xfer & src_tvalid[grant_q];
  assign m_axis_last  = xfer & src_tlast[grant_q];
  assign src_tready   = xfer ? (N_SRC'(m_axis_ready) << grant_q) : '0;
  assign hs           = m_axis_valid & m_axis_ready;
  // arbitration only from IDLE, so en/cfg changes mid-packet are ignored
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    cfg_d      = cfg_q;
    beat_d     = beat_q;
    pkt_done_d = 1'b0;
    if (!xfer && any_req) begin
      state_d  = XFER;
      grant_d  = win_idx;
      rr_ptr_d = (win_idx == IDX_W'(N_SRC - 1)) ? '0 : win_idx + 1'b1;
      cfg_d    = win_cfg;
      beat_d   = '0;
    end
    if (hs) begin
      beat_d     = (&beat_q) ? beat_q : beat_q + 1'b1;
      state_d    = m_axis_last ? IDLE : state_d;
      pkt_done_d = m_axis_last;
    end
  end
  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      cfg_q      <= '0;
      beat_q     <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      cfg_q      <= cfg_d;
      beat_q     <= beat_d;
      pkt_done_q <= pkt_done_d;
    end
  end
  assign cfg      = cfg_q;
  assign grant_id = grant_q;
  assign busy     = xfer;
  assign pkt_done = pkt_done_q;
  assign beat_cnt = beat_q;
endmodule

// File: doc/axis_pkt_arbiter.md
AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

Interface
REQ-001 Parameter N_SRC, default 4, number of AXI-Stream requesters (2..8).
REQ-002 Parameter DATA_W, default 64, beat width; equals WIDTH_P of the downstream axi_cdc.
REQ-003 Parameter CFG_W, default 2, width of the per-source cfg word driven to axi_cdc.
REQ-004 clk_p  input  1  single clock; all logic on rising edge.
REQ-005 rst_p  input  1  reset, synchronous, active-high.
REQ-006 src_tdata  input  N_SRC*DATA_W  packed source data, source i at bits [i*DATA_W +: DATA_W].
REQ-007 src_tvalid  input  N_SRC  per-source valid.
REQ-008 src_tlast  input  N_SRC  per-source end of packet.
REQ-009 src_tready  output  N_SRC  per-source ready.
REQ-010 src_cfg  input  N_SRC*CFG_W  per-source cfg word.
REQ-011 src_en  input  N_SRC  per-source arbitration enable.
REQ-012 m_axis_data  output  DATA_W  to axi_cdc p_axis_data.
REQ-013 m_axis_valid  output  1  to axi_cdc p_axis_valid.
REQ-014 m_axis_last  output  1  to axi_cdc p_axis_last.
REQ-015 m_axis_ready  input  1  from axi_cdc p_axis_ready.
REQ-016 cfg  output  CFG_W  to axi_cdc cfg; held for the whole packet.
REQ-017 grant_id  output  $clog2(N_SRC)  index of the granted source.
REQ-018 busy  output  1  high while in XFER.
REQ-019 pkt_done  output  1  one-cycle pulse on the cycle after a tlast handshake.
REQ-020 beat_cnt  output  16  beats of the current or last packet, saturating at 16'hFFFF.

Function
REQ-021 FSM states IDLE and XFER only.
REQ-022 IDLE: request vector = src_tvalid & src_en; if non-zero, register the winner into grant_id, latch its src_cfg into cfg, clear beat_cnt, go to XFER next cycle; arbitration latency is one cycle.
REQ-023 Round-robin: search starts at rr_ptr and wraps at N_SRC-1 -> 0; on grant, rr_ptr <= winner+1 modulo N_SRC.
REQ-024 XFER: m_axis_data/valid/last = granted source's tdata/tvalid/tlast combinationally; src_tready[grant_id] = m_axis_ready; all other src_tready = 0.
REQ-025 In IDLE: all src_tready = 0, m_axis_valid = 0.
REQ-026 Each m_axis_valid & m_axis_ready cycle increments beat_cnt, saturating.
REQ-027 Handshake with m_axis_last = 1: go to IDLE, pkt_done = 1 next cycle; the next grant occurs at earliest one cycle after that (one bubble cycle per packet).
REQ-028 Grant is packet-locked: src_en or src_cfg changes during XFER do not affect the current packet; cfg changes only in IDLE at grant.
REQ-029 Granted source dropping tvalid mid-packet: stay in XFER, m_axis_valid = 0, no timeout.
REQ-030 Single-beat packet (tlast on first beat): one XFER cycle with handshake, beat_cnt = 1.
REQ-031 m_axis_ready low: no state change, data/last passthrough stable as driven by source (AXI-Stream rules are the source's obligation).

Reset
REQ-032 rst_p high at a clock edge: state IDLE, rr_ptr 0, grant_id 0, cfg 0, beat_cnt 0, pkt_done 0, busy 0, all src_tready 0, m_axis_valid 0.
REQ-033 Reset mid-packet abandons the packet; no pkt_done generated; source 0 has priority on the first arbitration after reset.

Structure
REQ-034 Package axis_arb_pkg holds the state enum (IDLE, XFER), default parameter constants, and BEAT_CNT_W = 16.
REQ-035 Sub-module rr_picker (combinational: request vector, pointer -> one-hot grant, index, any_req) is instantiated once.

Verification
REQ-036 Sources 0 and 2 each send a 3-beat packet simultaneously after reset, m_axis_ready = 1 -> source 0 first, then source 2; beat_cnt = 3 and a pkt_done pulse for each.
REQ-037 All 4 sources continuously valid with 1-beat packets -> grant order 0,1,2,3,0; each pkt_done is one cycle apart from the next grant.
REQ-038 src_cfg[1] = 2'b10, source 1 sends 4 beats; src_cfg[1] changes to 2'b01 after beat 2 -> cfg = 2'b10 for all 4 beats.
REQ-039 m_axis_ready toggles 1,0,0,1 during a 5-beat packet -> no beat lost or duplicated; beat_cnt = 5.
REQ-040 src_en = 4'b1011 with all sources valid -> source 2 never granted.
REQ-041 rst_p asserted for 1 cycle after beat 2 of a packet from source 3 -> next cycle IDLE with all outputs at reset values; no pkt_done; next grant goes to source 0.
